// File: rtl/eye_pkg.sv
// Shared fetch-side types and defaults for the 16-bit core.
package eye_pkg;

    localparam int PC_W = 16;
    localparam logic [PC_W-1:0] RESET_PC = 16'h0000;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2,
        HALT  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/fetch_ctrl_if.sv
// Fetch bundle: branch/halt control in, imem req/ack, decode valid/ready out.
// master is the fetch sequencer side; slave is memory + decode + branch unit.
interface fetch_ctrl_if #(
    parameter int PC_W = 16
) ();

    logic            jmp_true;
    logic [PC_W-1:0] jmp_target;
    logic            halt;
    logic            imem_req;
    logic [PC_W-1:0] imem_addr;
    logic            imem_ack;
    logic [PC_W-1:0] imem_data;
    logic            if_valid;
    logic [PC_W-1:0] if_instr;
    logic [PC_W-1:0] if_pc;
    logic            if_ready;
    logic            flush;

    modport master (
        input  jmp_true, jmp_target, halt, imem_ack, imem_data, if_ready,
        output imem_req, imem_addr, if_valid, if_instr, if_pc, flush
    );

    modport slave (
        output jmp_true, jmp_target, halt, imem_ack, imem_data, if_ready,
        input  imem_req, imem_addr, if_valid, if_instr, if_pc, flush
    );

endinterface

// File: rtl/fetch_buf.sv
// One-entry fetch output register; loads one cycle after ack, clear beats load beats consume.
// Holds instr/pc stable while valid and not ready.
module fetch_buf
    import eye_pkg::*;
#(
    parameter int W = PC_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_load,
    input  logic         i_clear,
    input  logic         i_ready,
    input  logic [W-1:0] i_instr,
    input  logic [W-1:0] i_pc,
    output logic         o_valid,
    output logic [W-1:0] o_instr,
    output logic [W-1:0] o_pc
);

    logic         r_valid;
    logic [W-1:0] r_instr;
    logic [W-1:0] r_pc;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_valid <= 1'b0;
            r_instr <= '0;
            r_pc    <= '0;
        end else if (i_clear) begin
            r_valid <= 1'b0;
        end else if (i_load) begin
            r_valid <= 1'b1;
            r_instr <= i_instr;
            r_pc    <= i_pc;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    assign o_valid = r_valid;
    assign o_instr = r_instr;
    assign o_pc    = r_pc;

endmodule

// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: owns PC, issues imem reads, applies redirects; zero-wait gives 1 instr/cycle.
// Backpressure: a new request is issued only when the output buffer has space; req never depends on ack.
module fetch_ctrl
    import eye_pkg::*;
#(
    parameter int              PC_W     = eye_pkg::PC_W,
    parameter logic [PC_W-1:0] RESET_PC = eye_pkg::RESET_PC
) (
    input  logic         clk,
    input  logic         rst_n,
    fetch_ctrl_if.master bus
);

    localparam logic [PC_W-1:0] PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};

    fetch_state_t    r_state;
    fetch_state_t    w_state_nxt;
    logic [PC_W-1:0] r_pc;
    logic [PC_W-1:0] w_pc_nxt;
    logic [PC_W-1:0] r_fetch_addr;
    logic [PC_W-1:0] w_fetch_addr_nxt;
    logic [PC_W-1:0] w_addr;
    logic            w_req;
    logic            w_load;
    logic            w_clear;
    logic            w_space;
    logic            w_buf_vld;

    assign w_space = !w_buf_vld || bus.if_ready;

    always_comb begin
        w_state_nxt      = r_state;
        w_pc_nxt         = r_pc;
        w_fetch_addr_nxt = r_fetch_addr;
        w_addr           = r_fetch_addr;
        w_req            = 1'b0;
        w_load           = 1'b0;
        w_clear          = 1'b0;
        case (r_state)
            IDLE: begin
                if (bus.jmp_true) begin
                    w_pc_nxt = bus.jmp_target;
                    w_clear  = 1'b1;
                end else if (bus.halt) begin
                    w_state_nxt = HALT;
                end else if (w_space) begin
                    w_req            = 1'b1;
                    w_addr           = r_pc;
                    w_fetch_addr_nxt = r_pc;
                    if (bus.imem_ack) begin
                        w_load   = 1'b1;
                        w_pc_nxt = r_pc + PC_ONE;
                    end else begin
                        w_state_nxt = BUSY;
                    end
                end
            end
            BUSY: begin
                w_req = 1'b1;
                if (bus.jmp_true) begin
                    w_pc_nxt    = bus.jmp_target;
                    w_clear     = 1'b1;
                    w_state_nxt = bus.imem_ack ? IDLE : DRAIN;
                end else if (bus.imem_ack) begin
                    w_load      = 1'b1;
                    w_pc_nxt    = r_pc + PC_ONE;
                    w_state_nxt = IDLE;
                end
            end
            DRAIN: begin
                // Stale request must still complete; its data is dropped.
                w_req = 1'b1;
                if (bus.jmp_true) begin
                    w_pc_nxt = bus.jmp_target;
                    w_clear  = 1'b1;
                end
                if (bus.imem_ack) begin
                    w_state_nxt = IDLE;
                end
            end
            HALT: begin
                w_state_nxt = HALT;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_pc         <= RESET_PC;
            r_fetch_addr <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_pc         <= w_pc_nxt;
            r_fetch_addr <= w_fetch_addr_nxt;
        end
    end

    fetch_buf #(
        .W (PC_W)
    ) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_load  (w_load),
        .i_clear (w_clear),
        .i_ready (bus.if_ready),
        .i_instr (bus.imem_data),
        .i_pc    (w_addr),
        .o_valid (w_buf_vld),
        .o_instr (bus.if_instr),
        .o_pc    (bus.if_pc)
    );

    assign bus.imem_req  = w_req && rst_n;
    assign bus.imem_addr = w_addr;
    assign bus.if_valid  = w_buf_vld;
    assign bus.flush     = bus.jmp_true;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios plus random redirects/stalls/latencies
// against a transaction-level model of the fetch stream.
module tb_fetch_ctrl;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    fetch_ctrl_if #(.PC_W(16)) bus ();

    fetch_ctrl #(
        .PC_W     (16),
        .RESET_PC (16'h0000)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_pass  = 0;
    int n_fail  = 0;
    int n_total = 0;

    // Model of the architectural fetch stream
    logic        m_valid;
    logic [15:0] m_instr;
    logic [15:0] m_bpc;
    logic [15:0] m_pc;
    logic [15:0] m_faddr;
    bit          m_out;
    bit          m_stale;
    bit          m_halted;

    // Memory responder
    int mem_wait;
    int mem_lat;
    bit rand_lat;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return {a[7:0], a[15:8]} ^ 16'hC3A5;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_valid  = 1'b0;
        m_instr  = 16'h0;
        m_bpc    = 16'h0;
        m_pc     = 16'h0000;
        m_faddr  = 16'h0;
        m_out    = 1'b0;
        m_stale  = 1'b0;
        m_halted = 1'b0;
        mem_wait = 0;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n          = 1'b0;
        bus.jmp_true   = 1'b0;
        bus.jmp_target = 16'h0;
        bus.halt       = 1'b0;
        bus.if_ready   = 1'b0;
        bus.imem_ack   = 1'b0;
        #1;
        check("req_in_reset", {31'd0, bus.imem_req}, 32'd0);
        model_reset();
    endtask

    task automatic step(input logic jmp, input logic [15:0] tgt, input logic hlt, input logic rdy);
        logic        exp_req;
        logic [15:0] exp_addr;
        logic        ack;
        logic        good;
        bit          was_out;
        @(posedge clk);
        #1;
        rst_n          = 1'b1;
        bus.jmp_true   = jmp;
        bus.jmp_target = tgt;
        bus.halt       = hlt;
        bus.if_ready   = rdy;
        bus.imem_ack   = 1'b0;
        #1;
        check("if_valid", {31'd0, bus.if_valid}, {31'd0, m_valid});
        if (m_valid) begin
            check("if_pc", {16'd0, bus.if_pc}, {16'd0, m_bpc});
            check("if_instr", {16'd0, bus.if_instr}, {16'd0, m_instr});
        end
        check("flush", {31'd0, bus.flush}, {31'd0, jmp});
        if (m_halted)   exp_req = 1'b0;
        else if (m_out) exp_req = 1'b1;
        else            exp_req = (!m_valid || rdy) && !jmp && !hlt;
        check("imem_req", {31'd0, bus.imem_req}, {31'd0, exp_req});
        exp_addr = m_out ? m_faddr : m_pc;
        if (exp_req) check("imem_addr", {16'd0, bus.imem_addr}, {16'd0, exp_addr});

        ack = 1'b0;
        if (bus.imem_req) begin
            if (mem_wait >= mem_lat) begin
                ack           = 1'b1;
                bus.imem_data = mem_word(bus.imem_addr);
                mem_wait      = 0;
                if (rand_lat) mem_lat = $urandom_range(0, 3);
            end else begin
                mem_wait++;
            end
        end else begin
            mem_wait = 0;
        end
        bus.imem_ack = ack;

        was_out = m_out;
        if (exp_req && !m_out) begin
            m_faddr = m_pc;
            m_stale = 1'b0;
        end
        if (exp_req && jmp) m_stale = 1'b1;
        good = ack && exp_req && !m_stale;
        if (!m_halted && jmp) begin
            m_valid = 1'b0;
            m_pc    = tgt;
        end else if (good) begin
            m_valid = 1'b1;
            m_instr = mem_word(m_faddr);
            m_bpc   = m_faddr;
            m_pc    = m_faddr + 16'd1;
        end else if (rdy) begin
            m_valid = 1'b0;
        end
        m_out = exp_req && !ack;
        if (!m_halted && !was_out && !jmp && hlt) m_halted = 1'b1;
    endtask

    initial begin
        rst_n          = 1'b0;
        bus.jmp_true   = 1'b0;
        bus.jmp_target = 16'h0;
        bus.halt       = 1'b0;
        bus.if_ready   = 1'b0;
        bus.imem_ack   = 1'b0;
        bus.imem_data  = 16'h0;
        rand_lat       = 1'b0;
        mem_lat        = 0;
        model_reset();

        // Reset and zero-wait streaming
        do_reset();
        step(1'b0, 16'h0, 1'b0, 1'b1);
        check("rst_if_valid", {31'd0, bus.if_valid}, 32'd0);
        check("rst_if_instr", {16'd0, bus.if_instr}, 32'd0);
        check("rst_if_pc", {16'd0, bus.if_pc}, 32'd0);
        check("zw_addr0", {16'd0, bus.imem_addr}, 32'h0);
        for (int i = 1; i < 4; i++) begin
            step(1'b0, 16'h0, 1'b0, 1'b1);
            check("zw_addr", {16'd0, bus.imem_addr}, i);
            check("zw_valid", {31'd0, bus.if_valid}, 32'd1);
            check("zw_if_pc", {16'd0, bus.if_pc}, i - 1);
        end

        // Stalled decode then 2-cycle ack
        mem_lat = 2;
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 16'h0, 1'b0, 1'b0);
            check("stall_no_req", {31'd0, bus.imem_req}, 32'd0);
            check("stall_instr", {16'd0, bus.if_instr}, {16'd0, mem_word(16'h3)});
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 16'h0, 1'b0, 1'b1);
            check("slow_addr_held", {16'd0, bus.imem_addr}, 32'h4);
        end
        step(1'b0, 16'h0, 1'b0, 1'b1);
        check("slow_if_pc", {16'd0, bus.if_pc}, 32'h4);
        check("slow_next_addr", {16'd0, bus.imem_addr}, 32'h5);

        // Redirect while BUSY, stale ack one cycle later
        step(1'b1, 16'h0040, 1'b0, 1'b1);
        check("jmp_flush", {31'd0, bus.flush}, 32'd1);
        step(1'b0, 16'h0, 1'b0, 1'b1);
        check("drain_flush_low", {31'd0, bus.flush}, 32'd0);
        check("drain_addr", {16'd0, bus.imem_addr}, 32'h5);
        mem_lat = 0;
        step(1'b0, 16'h0, 1'b0, 1'b1);
        check("tgt_addr", {16'd0, bus.imem_addr}, 32'h40);
        check("stale_dropped", {31'd0, bus.if_valid}, 32'd0);
        step(1'b0, 16'h0, 1'b0, 1'b1);
        check("tgt_if_pc", {16'd0, bus.if_pc}, 32'h40);

        // PC wrap
        step(1'b1, 16'hFFFF, 1'b0, 1'b1);
        step(1'b0, 16'h0, 1'b0, 1'b1);
        check("wrap_ffff", {16'd0, bus.imem_addr}, 32'hFFFF);
        step(1'b0, 16'h0, 1'b0, 1'b1);
        check("wrap_0000", {16'd0, bus.imem_addr}, 32'h0);

        // Reset while a request is outstanding
        mem_lat = 3;
        step(1'b0, 16'h0, 1'b0, 1'b1);
        step(1'b0, 16'h0, 1'b0, 1'b1);
        do_reset();
        step(1'b0, 16'h0, 1'b0, 1'b1);
        check("rst_busy_req", {31'd0, bus.imem_req}, 32'd1);
        check("rst_busy_addr", {16'd0, bus.imem_addr}, 32'h0);
        check("rst_busy_valid", {31'd0, bus.if_valid}, 32'd0);

        // Random redirects, stalls and latencies
        rand_lat = 1'b1;
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 7) == 0), 16'($urandom()), 1'b0, ($urandom_range(0, 9) < 7));
        end
        rand_lat = 1'b0;
        mem_lat  = 0;
        for (int i = 0; i < 4; i++) step(1'b0, 16'h0, 1'b0, 1'b1);

        // Halt together with redirect, then halt alone
        step(1'b1, 16'h0100, 1'b1, 1'b1);
        check("jh_no_req", {31'd0, bus.imem_req}, 32'd0);
        step(1'b0, 16'h0, 1'b0, 1'b1);
        check("jh_tgt_req", {31'd0, bus.imem_req}, 32'd1);
        check("jh_tgt_addr", {16'd0, bus.imem_addr}, 32'h100);
        step(1'b0, 16'h0, 1'b1, 1'b1);
        check("halt_req", {31'd0, bus.imem_req}, 32'd0);
        step(1'b1, 16'h0200, 1'b0, 1'b1);
        check("halt_jmp_ignored", {31'd0, bus.imem_req}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 16'h0, 1'b0, 1'b1);
            check("halt_sticky", {31'd0, bus.imem_req}, 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
